// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: one SLICE-bit rbcla_adder is reused for
// WIDTH/SLICE cycles, with the inter-slice carry held in a register.

module rbcla_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_BLOCK = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic [WIDTH-1:0] SUM,
  output logic             CO
);
  localparam int NB = WIDTH / BITS_PER_BLOCK;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_c;
  logic [NB:0]      w_bc;
  logic             w_bg;
  logic             w_bp;

  // Block carries skip across each block via group generate/propagate;
  // inside a block the carry ripples to form the per-bit sums.
  always_comb begin
    w_g   = A & B;
    w_p   = A ^ B;
    w_c   = '0;
    w_bc  = '0;
    w_bg  = 1'b0;
    w_bp  = 1'b1;
    w_bc[0] = CI;
    for (int b = 0; b < NB; b++) begin
      w_bg = 1'b0;
      w_bp = 1'b1;
      for (int i = 0; i < BITS_PER_BLOCK; i++) begin
        w_bg = w_g[b*BITS_PER_BLOCK+i] | (w_p[b*BITS_PER_BLOCK+i] & w_bg);
        w_bp = w_bp & w_p[b*BITS_PER_BLOCK+i];
      end
      w_bc[b+1] = w_bg | (w_bp & w_bc[b]);
      w_c[b*BITS_PER_BLOCK] = w_bc[b];
      for (int i = 1; i < BITS_PER_BLOCK; i++) begin
        w_c[b*BITS_PER_BLOCK+i] = w_g[b*BITS_PER_BLOCK+i-1] |
                                  (w_p[b*BITS_PER_BLOCK+i-1] & w_c[b*BITS_PER_BLOCK+i-1]);
      end
    end
    SUM = w_p ^ w_c;
    CO  = w_bc[NB];
  end
endmodule

module mp_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8,
  parameter int BPB   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_cy;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_sum_sl;
  logic             w_co;
  logic             w_last;
  logic             w_accept;

  // Operands shift down one slice per RUN cycle, so the adder always reads
  // the low slice and, on the last slice, bit SLICE-1 is the operand sign.
  assign w_a_sl   = r_a[SLICE-1:0];
  assign w_b_sl   = r_b[SLICE-1:0];
  assign w_last   = (r_cnt == CW'(NSLICE - 1));
  assign w_accept = (r_state == S_IDLE) && req_valid;

  rbcla_adder #(
    .WIDTH          (SLICE),
    .BITS_PER_BLOCK (BPB)
  ) u_add (
    .A   (w_a_sl),
    .B   (w_b_sl),
    .CI  (r_cy),
    .SUM (w_sum_sl),
    .CO  (w_co)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= op_a;
      r_b <= sub ? ~op_b : op_b;
    end else if (r_state == S_RUN) begin
      r_a <= r_a >> SLICE;
      r_b <= r_b >> SLICE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cy    <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_cy    <= sub ? ~cin : cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (r_cnt == CW'(k)) r_sum[k*SLICE +: SLICE] <= w_sum_sl;
          end
          r_cy  <= w_co;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout  <= w_co;
            r_ovf   <= (w_a_sl[SLICE-1] ~^ w_b_sl[SLICE-1]) &
                       (w_a_sl[SLICE-1] ^ w_sum_sl[SLICE-1]);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign res_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
endmodule

// File: doc/mp_addsub_seq.md
Name: mp_addsub_seq

Overview:
Multi-precision add/subtract sequencer. It drives one narrow rbcla_adder instance (width = SLICE) over NSLICE consecutive cycles, chaining the carry through a register between slices. This gives WIDTH-bit add/subtract at the area of a SLICE-bit adder. It sits between the risc8 execute stage (or any requester) and the shared adder, using a valid/ready handshake on both sides.

Parameters:
WIDTH, 32, operand/result width in bits; must be an integer multiple of SLICE.
SLICE, 8, width of the instantiated rbcla_adder (its width parameter); bits processed per cycle.
BPB, 4, bits_per_block passed to the rbcla_adder; SLICE must be a multiple of BPB.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
req_valid  input  1  request present on op_a/op_b/sub/cin.
req_ready  output  1  block can accept a request (high only in IDLE).
op_a  input  WIDTH  operand A.
op_b  input  WIDTH  operand B.
sub  input  1  0: A+B+cin; 1: A-B-cin (cin acts as borrow-in).
cin  input  1  carry-in (sub=0) or borrow-in (sub=1).
res_valid  output  1  result outputs valid.
res_ready  input  1  consumer accepts result.
sum  output  WIDTH  result.
cout  output  1  carry-out; for sub, 1 = no borrow.
ovf  output  1  two's-complement signed overflow.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE, slice counter=0, carry reg=0, sum=0, cout=0, ovf=0, res_valid=0, busy=0, req_ready=1 from the next cycle. Reset has priority over every other event, including mid-RUN and in DONE. The in-flight operation is discarded with no result.
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid=1 at an edge:
  - latch A=op_a and Beff = sub ? ~op_b : op_b;
  - carry reg = sub ? ~cin : cin;
  - counter=0; go to RUN.
- RUN (exactly NSLICE=WIDTH/SLICE cycles): each cycle the adder sees A[k*SLICE +: SLICE], Beff[k*SLICE +: SLICE], CI=carry reg, with k=counter. At the edge:
  - sum[k*SLICE +: SLICE] gets the adder SUM;
  - carry reg gets the adder CO;
  - counter increments.
  - When k=NSLICE-1: cout = adder CO; ovf = (A[WIDTH-1] ~^ Beff[WIDTH-1]) & (A[WIDTH-1] ^ adder SUM[SLICE-1]); go to DONE.
  - Inputs are ignored during RUN.
- DONE: res_valid=1; sum/cout/ovf held stable. On res_ready=1 at an edge: res_valid drops to 0 and the block goes to IDLE. A new request can be accepted on the following edge; there is no same-cycle turnaround.
- Latency: acceptance edge T → res_valid high from edge T+NSLICE (4 cycles for the defaults). Throughput: one operation per NSLICE+2 cycles with res_ready held high.
- Output update: sum slices may change during RUN. Consumers use sum/cout/ovf only while res_valid=1. Outputs keep the last result in IDLE until the next RUN overwrites them.
- Widths and arithmetic:
  - results are modulo 2^WIDTH;
  - inverting B and the carry-in implements A-B-cin exactly;
  - the counter is ceil(log2(NSLICE)) bits, min 1;
  - NSLICE=1 is legal: one RUN cycle.
- Handshake: req_ready and res_valid are registered-state decodes only, never combinational from inputs. They are never both 1.

Test Plan:
- Cross-slice carry: A=0x000000FF, B=0x00000001, sub=0, cin=0 → sum=0x00000100, cout=0, ovf=0, res_valid exactly 4 cycles after acceptance.
- Full wrap: A=0xFFFFFFFF, B=0x00000000, cin=1 → sum=0x00000000, cout=1, ovf=0. Then A=0x7FFFFFFF, B=0x00000001 → sum=0x80000000, cout=0, ovf=1.
- Subtract with borrow: sub=1, A=5, B=7, cin=0 → sum=0xFFFFFFFE, cout=0, ovf=0. Then sub=1, A=0x80000000, B=1, cin=1 → sum=0x7FFFFFFE, cout=1, ovf=1.
- Backpressure: hold res_ready=0 for 5 cycles in DONE → res_valid stays 1, outputs stable, req_ready=0, and a req_valid pulse is ignored. Then res_ready=1 → IDLE next cycle, and a new request is accepted on the following edge.
- Reset mid-op: assert rst_n=0 during the 2nd RUN cycle → next edge: IDLE, res_valid=0, sum=0, cout=0, ovf=0, and the discarded result never appears. A subsequent request 1+2 → sum=3.
- Random regression: 10k random A/B/sub/cin with random res_ready stalls, compared against a {cout,sum} = A±B±cin reference model. Repeat with SLICE=4, 16, 32.
